// File: rtl/rom_dbg_arbiter_pkg.sv
// mcs4 shared types, extended with the ROM debug-port arbiter's
// address type, FSM state encoding and error read-data constant.
package mcs4;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;

  // {chip_id, byte_addr[7:4], byte_addr[3:0]}
  typedef char_t [2:0] Dbg_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rom_dbg_state_t;

  localparam byte_t Dbg_err_data = 8'hFF;

endpackage

// File: rtl/rom_dbg_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer port wins when it requests;
// after an accepted grant the pointer moves to the other port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant the pointer port first, otherwise the other port.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[ptr]) begin
        gnt[ptr] = 1'b1;
      end else if (req[~ptr]) begin
        gnt[~ptr] = 1'b1;
      end
    end
  end

  // Every grant is an accept (ready follows grant), so advance past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_dbg_arbiter.sv
// Shares the i4001 ROM debug load/readback bus between the host loader
// (port 0) and the ROM scrubber (port 1). One transaction in flight at a
// time; busy lets the platform stall the CPU during debug reads.
// Optional: define ROM_DBG_WP_EN to add the per-chip wp_mask write protect.
//
// state | meaning
// IDLE  | arbitrate, latch the accepted request
// ISSUE | one-cycle dbg_wen / dbg_ren strobe
// WAIT  | wait for the addressed chip's readback, bounded by TIMEOUT
// RESP  | hold the response until the owning port accepts it
module rom_dbg_arbiter
  import mcs4::*;
#(
  parameter int NUM_ROMS = 16,
  parameter int TIMEOUT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_vld,
  output logic [1:0]               req_rdy,
  input  logic [1:0]               req_we,
  input  logic [1:0][11:0]         req_addr,
  input  logic [1:0][7:0]          req_wdata,
  output logic [1:0]               rsp_vld,
  input  logic [1:0]               rsp_rdy,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [11:0]              dbg_addr,
  output logic [7:0]               dbg_wdata,
  output logic                     dbg_wen,
  output logic                     dbg_ren,
`ifdef ROM_DBG_WP_EN
  input  logic [NUM_ROMS-1:0]      wp_mask,
`endif
  input  logic [NUM_ROMS-1:0][7:0] dbg_rdata,
  input  logic [NUM_ROMS-1:0]      dbg_rdata_vld
);

  rom_dbg_state_t state, state_n;
  logic           port_q, port_n;
  logic           we_q, we_n;
  Dbg_addr_t      addr_q, addr_n;
  byte_t          wdata_q, wdata_n;
  byte_t          data_q, data_n;
  logic           err_q, err_n;
  logic [3:0]     cnt_q, cnt_n;

  logic [1:0]          gnt;
  logic                gsel;
  Dbg_addr_t           new_addr;
  logic [NUM_ROMS-1:0] hit_new, hit_cur;
  logic                bad_chip, wp_hit, cur_vld;
  byte_t               cur_data;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state == IDLE) && !rst),
    .req (req_vld),
    .gnt (gnt)
  );

  assign gsel     = gnt[1];
  assign new_addr = req_addr[gsel];
  assign bad_chip = ({1'b0, new_addr[2]} >= 5'(NUM_ROMS));

  // One-hot chip decode for the incoming and the latched address; the
  // readback mux only listens to the latched chip's valid.
  always_comb begin
    hit_new  = '0;
    hit_cur  = '0;
    cur_data = '0;
    for (int i = 0; i < NUM_ROMS; i++) begin
      hit_new[i] = (new_addr[2] == 4'(i));
      hit_cur[i] = (addr_q[2] == 4'(i));
      cur_data   = cur_data | (dbg_rdata[i] & {8{hit_cur[i]}});
    end
  end

  assign cur_vld = |(hit_cur & dbg_rdata_vld);

`ifdef ROM_DBG_WP_EN
  assign wp_hit = |(hit_new & wp_mask);
`else
  assign wp_hit = 1'b0;
`endif

  // Next-state and datapath update; strobes and response valid are gated by
  // rst so they drop in the same cycle reset is sampled.
  always_comb begin
    state_n = state;
    port_n  = port_q;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    data_n  = data_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    rsp_vld = 2'b00;

    case (state)
      IDLE: begin
        if (|gnt) begin
          port_n  = gsel;
          we_n    = req_we[gsel];
          addr_n  = new_addr;
          wdata_n = req_wdata[gsel];
          if (bad_chip) begin
            state_n = RESP;
            err_n   = 1'b1;
            data_n  = Dbg_err_data;
          end else if (req_we[gsel] && wp_hit) begin
            state_n = RESP;
            err_n   = 1'b1;
            data_n  = '0;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_n = RESP;
          err_n   = 1'b0;
          data_n  = '0;
        end else begin
          state_n = WAIT;
          cnt_n   = 4'(TIMEOUT - 1);
        end
      end
      WAIT: begin
        if (cur_vld) begin
          state_n = RESP;
          err_n   = 1'b0;
          data_n  = cur_data;
        end else if (cnt_q == 4'd0) begin
          state_n = RESP;
          err_n   = 1'b1;
          data_n  = Dbg_err_data;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_vld[port_q] = !rst;
        if (rsp_rdy[port_q]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_rdy   = gnt;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state != IDLE);
  assign dbg_addr  = addr_q;
  assign dbg_wdata = wdata_q;
  assign dbg_wen   = (state == ISSUE) && we_q && !rst;
  assign dbg_ren   = (state == ISSUE) && !we_q && !rst;

  // State and datapath registers, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      port_q  <= port_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      data_q  <= data_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rom_dbg_arbiter.sv
// Bench for rom_dbg_arbiter with NUM_ROMS=4, TIMEOUT=4. A ROM stub model
// answers reads one cycle after dbg_ren; chip 1 never answers (and pokes
// chip 0's valid instead). Expected responses go into a queue at accept
// time and a monitor checks them when rsp_vld rises.
// Build with ROM_DBG_WP_EN defined to also exercise write protect.
module tb_rom_dbg_arbiter;

  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_vld;
  logic [1:0]       req_rdy;
  logic [1:0]       req_we;
  logic [1:0][11:0] req_addr;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       rsp_vld;
  logic [1:0]       rsp_rdy;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [11:0]      dbg_addr;
  logic [7:0]       dbg_wdata;
  logic             dbg_wen;
  logic             dbg_ren;
  logic [NR-1:0][7:0] dbg_rdata;
  logic [NR-1:0]    dbg_rdata_vld;
`ifdef ROM_DBG_WP_EN
  logic [NR-1:0]    wp_mask = 4'b0100;
`endif

  rom_dbg_arbiter #(.NUM_ROMS(NR), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wen(dbg_wen), .dbg_ren(dbg_ren),
`ifdef ROM_DBG_WP_EN
    .wp_mask(wp_mask),
`endif
    .dbg_rdata(dbg_rdata), .dbg_rdata_vld(dbg_rdata_vld)
  );

  always #5 clk = ~clk;

  // ROM stub: contents reset to c*37+a; reads answer one cycle later.
  logic [7:0] mem [NR][256];
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NR; c++)
        for (int a = 0; a < 256; a++)
          mem[c][a] <= 8'(c * 37 + a);
      dbg_rdata_vld <= '0;
      dbg_rdata     <= '0;
    end else begin
      dbg_rdata_vld <= '0;
      if (dbg_wen && dbg_addr[11:8] < 4'(NR))
        mem[dbg_addr[9:8]][dbg_addr[7:0]] <= dbg_wdata;
      if (dbg_ren) begin
        if (dbg_addr[11:8] == 4'd1) begin
          dbg_rdata_vld[0] <= 1'b1;
          dbg_rdata[0]     <= 8'h77;
        end else if (dbg_addr[11:8] < 4'(NR)) begin
          dbg_rdata_vld[dbg_addr[9:8]] <= 1'b1;
          dbg_rdata[dbg_addr[9:8]]     <= mem[dbg_addr[9:8]][dbg_addr[7:0]];
        end
      end
    end
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  logic [11:0] last_waddr;
  logic [7:0]  last_wdata;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];
  int   grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Strobe monitor: never both strobes, strobes only while busy.
  initial forever begin
    @(negedge clk);
    if (dbg_wen || dbg_ren) begin
      chk("strobe_excl", {30'd0, dbg_wen & dbg_ren, busy}, 32'd1);
      if (dbg_wen) begin
        wen_cnt++;
        last_waddr = dbg_addr;
        last_wdata = dbg_wdata;
      end
      if (dbg_ren) ren_cnt++;
    end
  end

  // Response monitor: compare on the first cycle of each response.
  initial begin : mon
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((|rsp_vld) && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {30'd0, rsp_vld}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", {30'd0, rsp_vld}, 32'(2'b01 << e.port));
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev = |rsp_vld;
    end
  end

  task automatic do_req(input int p, input logic we, input logic [11:0] addr,
                        input logic [7:0] wd, input logic [7:0] ed, input logic ee,
                        input int lat, input bit push);
    bit acc;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
    req_vld[p]   = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (req_rdy[p]) acc = 1'b1;
    end
    chk("accept", {31'd0, acc}, 32'd1);
    if (acc) begin
      grants.push_back(p);
      if (push) sb.push_back('{p, ed, ee, cyc, lat});
    end
    @(posedge clk);
    #1 req_vld[p] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_rdy"}, {30'd0, req_rdy}, 32'd0);
    chk({tag, "_rsp_vld"}, {30'd0, rsp_vld}, 32'd0);
    chk({tag, "_rsp_data_err"}, {23'd0, rsp_data, rsp_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_dbg_addr_wdata"}, {12'd0, dbg_addr, dbg_wdata}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, dbg_wen, dbg_ren}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, r0;
    bit seen;
    rst = 1'b1; req_vld = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rsp_rdy = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Port 0 write A5 -> 0x310.
    @(posedge clk); #1;
    w0 = wen_cnt;
    do_req(0, 1'b1, 12'h310, 8'hA5, 8'h00, 1'b0, 2, 1'b1);
    wait_idle();
    chk("wr_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("wr_addr", {20'd0, last_waddr}, 32'h310);
    chk("wr_wdata", {24'd0, last_wdata}, 32'hA5);

    // Port 1 reads it back; busy through ISSUE, WAIT, RESP.
    @(posedge clk); #1;
    do_req(1, 1'b0, 12'h310, 8'h00, 8'hA5, 1'b0, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_busy", {31'd0, busy}, 32'd1);
    end
    wait_idle();

    // Both ports requesting continuously: strict alternation from port 0.
    grants.delete();
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 4; i++)
        do_req(0, 1'b1, 12'(i), 8'(8'h10 + i), 8'h00, 1'b0, 2, 1'b1);
      for (int i = 0; i < 4; i++)
        do_req(1, 1'b0, 12'h310, 8'h00, 8'hA5, 1'b0, 3, 1'b1);
    join
    wait_idle();
    chk("alt_count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size(); i++)
      chk("alt_grant", 32'(grants[i]), 32'(i % 2));

    // Bad chip id: immediate error, no strobe.
    @(posedge clk); #1;
    w0 = wen_cnt; r0 = ren_cnt;
    do_req(0, 1'b0, 12'hF00, 8'h00, 8'hFF, 1'b1, 1, 1'b1);
    wait_idle();
    chk("bad_chip_strobes", 32'((wen_cnt - w0) + (ren_cnt - r0)), 32'd0);

    // Dead chip: timeout after 4 WAIT cycles, foreign vld ignored.
    @(posedge clk); #1;
    do_req(1, 1'b0, 12'h120, 8'h00, 8'hFF, 1'b1, 6, 1'b1);
    wait_idle();

    // Hold rsp_rdy[0] low for 5 cycles with port 1 waiting.
    @(posedge clk); #1;
    rsp_rdy = 2'b10;
    do_req(0, 1'b0, 12'h310, 8'h00, 8'hA5, 1'b0, 3, 1'b1);
    fork
      do_req(1, 1'b0, 12'h000, 8'h00, 8'h10, 1'b0, 3, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (rsp_vld[0]) seen = 1'b1;
        end
        chk("hold_seen", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("hold_vld", {30'd0, rsp_vld}, 32'd1);
          chk("hold_data_err", {23'd0, rsp_data, rsp_err}, {23'd0, 8'hA5, 1'b0});
          chk("hold_no_grant", {30'd0, req_rdy}, 32'd0);
        end
        #2 rsp_rdy[0] = 1'b1;
        #1 chk("rdy_cycle_no_grant", {30'd0, req_rdy}, 32'd0);
      end
    join
    wait_idle();
    rsp_rdy = 2'b11;

    // Reset during WAIT on the dead chip: response dropped.
    @(posedge clk); #1;
    do_req(1, 1'b0, 12'h120, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|rsp_vld) seen = 1'b1;
    end
    chk("rsp_dropped", {31'd0, seen}, 32'd0);

`ifdef ROM_DBG_WP_EN
    // Write-protected chip 2: write refused, read still works (reset contents).
    @(posedge clk); #1;
    w0 = wen_cnt;
    do_req(0, 1'b1, 12'h200, 8'h5A, 8'h00, 1'b1, 1, 1'b1);
    wait_idle();
    chk("wp_no_wen", 32'(wen_cnt - w0), 32'd0);
    @(posedge clk); #1;
    do_req(1, 1'b0, 12'h200, 8'h00, 8'h4A, 1'b0, 3, 1'b1);
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_dbg_arbiter.md
Name: rom_dbg_arbiter

Overview:
- Sequences and shares the debug load/readback port of a bank of i4001 ROM chips between two requesters.
- Port 0 is the host loader (PS-side bridge); port 1 is the ROM scrubber/checker.
- Issues single-cycle dbg_wen/dbg_ren strobes, waits for the per-chip registered readback, and returns one response per request.
- Asserts busy so the platform can stall the CPU while a debug read is in progress, because the chip's fetch data register does not update during a debug read.

Parameters:
- NUM_ROMS, 16: number of i4001 instances on the shared debug bus (1..16); chip IDs 0..NUM_ROMS-1.
- TIMEOUT, 4: cycles to wait in WAIT for dbg_rdata_vld before failing the read (2..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  [1:0]  per-port request valid
- req_rdy  out  [1:0]  per-port request accept
- req_we  in  [1:0]  1 = write, 0 = read
- req_addr  in  [1:0][11:0]  {chip_id[11:8], byte_addr[7:0]} (mcs4::char_t [2:0])
- req_wdata  in  [1:0][7:0]  write byte
- rsp_vld  out  [1:0]  per-port response valid
- rsp_rdy  in  [1:0]  per-port response accept
- rsp_data  out  [7:0]  read data; shared by both ports and meaningful only on the port with rsp_vld
- rsp_err  out  1  error flag qualifying rsp_data
- busy  out  1  transaction in flight
- dbg_addr  out  12  shared debug address to all ROMs
- dbg_wdata  out  8  shared debug write data
- dbg_wen  out  1  write strobe
- dbg_ren  out  1  read strobe
- dbg_rdata  in  [NUM_ROMS-1:0][7:0]  per-chip readback
- dbg_rdata_vld  in  [NUM_ROMS-1:0]  per-chip readback valid
- wp_mask  in  [NUM_ROMS-1:0]  per-chip write protect (present only with ROM_DBG_WP_EN)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = port 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_rdy[g] = 1 only for the granted port g, combinational from req_vld and the pointer.
  - Grant goes to the pointer port if it is requesting, otherwise to the other port.
  - On accept, latch port, we, addr and wdata; go to ISSUE. Pointer moves to the non-granted port.
  - If chip_id >= NUM_ROMS, go directly to RESP with err=1, data=8'hFF, and no strobe issued.
- ISSUE (exactly 1 cycle):
  - Drive dbg_wen=we or dbg_ren=!we.
  - Write: go to RESP with err=0, data=0.
  - Read: go to WAIT.
- WAIT:
  - Capture dbg_rdata[chip] when dbg_rdata_vld[chip]; go to RESP with err=0. Nominal arrival is the first WAIT cycle.
  - The vld bits of other chips are ignored.
  - A wait counter counts WAIT cycles. After TIMEOUT cycles without vld, go to RESP with err=1, data=8'hFF.
- RESP:
  - rsp_vld[port]=1, with rsp_data and rsp_err held stable until rsp_rdy[port].
  - On rsp_rdy, return to IDLE.
  - No new grant is made in the cycle rsp_rdy is seen.
- Strobes and address/data:
  - dbg_wen and dbg_ren are high only in ISSUE, and never both high.
  - dbg_addr and dbg_wdata are registered and held from ISSUE through the end of WAIT.
- busy: 1 in ISSUE, WAIT and RESP; 0 in IDLE.
- Latency:
  - Write: accept -> rsp_vld = 2 cycles.
  - Read: 3 cycles nominal.
  - Bad chip ID: 1 cycle.
- Simultaneous requests alternate strictly. Back-to-back requests from one port while the other is idle are all served.
- Reset mid-operation: FSM returns to IDLE, strobes drop the same cycle as rst is sampled, and the pending response is discarded.

Optional Feature:
- ROM_DBG_WP_EN defined:
  - The wp_mask port exists.
  - A write to a chip with wp_mask[chip]=1 skips ISSUE and goes to RESP with err=1, data=0. No dbg_wen is issued.
  - Reads are unaffected.
- Undefined: the wp_mask port is absent and all writes proceed.

Decomposition:
- mcs4 package gets:
  - Dbg_addr_t (char_t [2:0]).
  - rom_dbg_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Constant Dbg_err_data = 8'hFF.
- Reuse mcs4::byte_t and mcs4::char_t.
- One sub-module: rr_arb2, a 2-way round-robin grant with pointer update on accept, used for the IDLE grant.

Test Plan:
- Port 0 writes 8'hA5 to addr 12'h3_10 -> one dbg_wen pulse with dbg_addr=12'h310, dbg_wdata=8'hA5; rsp_vld[0] 2 cycles after accept, err=0.
- Port 1 reads 12'h3_10 from a stub returning vld one cycle after dbg_ren -> rsp_data=8'hA5, err=0, rsp_vld[1] 3 cycles after accept, busy high throughout.
- Both ports assert req_vld continuously for 4 requests each -> grants 0,1,0,1,...; never two strobes in one cycle.
- Read with chip_id=4'hF and NUM_ROMS=4 -> no strobe, rsp err=1, data=8'hFF after 1 cycle. Read of a chip whose stub never asserts vld -> err after TIMEOUT=4 WAIT cycles.
- Hold rsp_rdy=0 for 5 cycles -> rsp_data/rsp_err stable and no new grant. Assert rst during WAIT -> next cycle all outputs 0 and the response is dropped.
- With ROM_DBG_WP_EN and wp_mask[2]=1, write to 12'h2_00 -> no dbg_wen, err=1. A read of the same address succeeds.
